// File: rtl/mem_pkg.sv
// mem_pkg: shared types and constants for the memory-port initiator.
//   mem_addr_t / mem_data_t : default-width address and data words
//   mem_rsp_t               : one buffered read response {addr, data}
//   MEM_READ_LATENCY        : cycles from mem_re to valid mem_rdata
//   cnt_width()             : width of an occupancy counter for a given depth
package mem_pkg;

  localparam int MEM_AWIDTH = 16;
  localparam int MEM_DWIDTH = 16;
  localparam int MEM_READ_LATENCY = 1;

  typedef logic [MEM_AWIDTH-1:0] mem_addr_t;
  typedef logic [MEM_DWIDTH-1:0] mem_data_t;

  typedef struct packed {
    mem_addr_t addr;
    mem_data_t data;
  } mem_rsp_t;

  // Occupancy must represent 0..depth inclusive, hence one bit above the pointer width.
  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock in-order FIFO for response entries.
// Ports:
//   clk, rst          : clock, synchronous active-high reset (flushes pointers, count, storage)
//   push_i, wdata_i   : write strobe and entry (ignored when full)
//   pop_i             : read strobe (ignored when empty)
//   rdata_o           : head entry (zero after reset)
//   full_o, empty_o   : status; empty_o is a register
//   count_o           : current occupancy, 0..DEPTH
// DEPTH must be a power of two so pointers wrap naturally.
module sync_fifo
  import mem_pkg::*;
#(
  parameter int WIDTH = $bits(mem_rsp_t),
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push_i,
  input  logic [WIDTH-1:0]             wdata_i,
  input  logic                         pop_i,
  output logic [WIDTH-1:0]             rdata_o,
  output logic                         full_o,
  output logic                         empty_o,
  output logic [cnt_width(DEPTH)-1:0]  count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = cnt_width(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wptr_q;
  logic [PW-1:0]    rptr_q;
  logic [CW-1:0]    count_q;
  logic [CW-1:0]    count_d;
  logic             empty_q;
  logic             push_s;
  logic             pop_s;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = empty_q;
  assign count_o = count_q;
  assign rdata_o = mem_q[rptr_q];
  assign push_s  = push_i & ~full_o;
  assign pop_s   = pop_i & ~empty_q;

  // Next occupancy; simultaneous push and pop cancel out.
  always_comb begin
    count_d = count_q;
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Storage, pointers and status registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= {PW{1'b0}};
      rptr_q  <= {PW{1'b0}};
      count_q <= {CW{1'b0}};
      empty_q <= 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {WIDTH{1'b0}};
      end
    end else begin
      if (push_s) begin
        mem_q[wptr_q] <= wdata_i;
        wptr_q        <= wptr_q + PW'(1);
      end
      if (pop_s) begin
        rptr_q <= rptr_q + PW'(1);
      end
      count_q <= count_d;
      empty_q <= (count_d == {CW{1'b0}});
    end
  end

endmodule

// File: rtl/mem_master.sv
// mem_master: request-stream initiator for the simulation memory port.
// Ports:
//   clk, rst                     : clock, synchronous active-high reset
//   req_valid/ready/we/addr/wdata: request stream (reads and posted writes)
//   rsp_valid/ready/rdata/addr   : in-order read response stream (registered)
//   mem_re/raddr, mem_rdata      : memory read port (data registered, valid next cycle)
//   mem_we/waddr/wdata           : memory write port
//   stat_rd_count/stat_wr_count  : accepted read/write counters, only when
//                                  MEM_MASTER_STATS_EN is defined
// Flow control is credit based: a request is accepted only while buffered
// plus in-flight reads leave room in the response FIFO, so it cannot overflow.
module mem_master
  import mem_pkg::*;
#(
  parameter int AWIDTH    = 16,
  parameter int DWIDTH    = 16,
  parameter int RSP_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [AWIDTH-1:0] req_addr,
  input  logic [DWIDTH-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DWIDTH-1:0] rsp_rdata,
  output logic [AWIDTH-1:0] rsp_addr,
  output logic              mem_re,
  output logic [AWIDTH-1:0] mem_raddr,
  input  logic [DWIDTH-1:0] mem_rdata,
  output logic              mem_we,
  output logic [AWIDTH-1:0] mem_waddr,
  output logic [DWIDTH-1:0] mem_wdata
`ifdef MEM_MASTER_STATS_EN
  ,
  output logic [31:0]       stat_rd_count,
  output logic [31:0]       stat_wr_count
`endif
);

  localparam int CW = cnt_width(RSP_DEPTH);
  localparam int EW = AWIDTH + DWIDTH;

  logic              inflight_q;
  logic              inflight_d;
  logic [AWIDTH-1:0] inflight_addr_q;
  logic [CW-1:0]     occ_s;
  logic [CW:0]       credit_s;
  logic              accept_s;
  logic              fifo_full_s;
  logic              fifo_empty_s;
  logic              push_s;
  logic [EW-1:0]     head_s;

  // Credit uses only registered state, so rsp_ready never reaches req_ready.
  assign credit_s  = {1'b0, occ_s} + {{CW{1'b0}}, inflight_q};
  assign req_ready = ~rst & (credit_s < (CW+1)'(RSP_DEPTH));
  assign accept_s  = req_valid & req_ready;

  assign mem_re    = accept_s & ~req_we;
  assign mem_we    = accept_s & req_we;
  assign mem_raddr = req_addr;
  assign mem_waddr = req_addr;
  assign mem_wdata = req_wdata;

  assign inflight_d = mem_re;
  // Credit already keeps the FIFO from filling; the full gate is only a backstop.
  assign push_s     = inflight_q & ~fifo_full_s;

  // Read tracking: remember the address of the read whose data arrives next cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      inflight_q      <= 1'b0;
      inflight_addr_q <= {AWIDTH{1'b0}};
    end else begin
      inflight_q <= inflight_d;
      if (mem_re) begin
        inflight_addr_q <= req_addr;
      end
    end
  end

  sync_fifo #(
    .WIDTH (EW),
    .DEPTH (RSP_DEPTH)
  ) u_rsp_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push_s),
    .wdata_i ({inflight_addr_q, mem_rdata}),
    .pop_i   (rsp_ready),
    .rdata_o (head_s),
    .full_o  (fifo_full_s),
    .empty_o (fifo_empty_s),
    .count_o (occ_s)
  );

  assign rsp_valid = ~fifo_empty_s;
  assign rsp_addr  = head_s[EW-1:DWIDTH];
  assign rsp_rdata = head_s[DWIDTH-1:0];

`ifdef MEM_MASTER_STATS_EN
  logic [31:0] rd_cnt_q;
  logic [31:0] wr_cnt_q;

  // Accepted-request counters; wrap naturally at 2^32.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_cnt_q <= 32'd0;
      wr_cnt_q <= 32'd0;
    end else begin
      if (mem_re) begin
        rd_cnt_q <= rd_cnt_q + 32'd1;
      end
      if (mem_we) begin
        wr_cnt_q <= wr_cnt_q + 32'd1;
      end
    end
  end

  assign stat_rd_count = rd_cnt_q;
  assign stat_wr_count = wr_cnt_q;
`endif

endmodule

// File: doc/mem_master.md
# mem_master

Initiator for the simulation memory port: accepts a stream of read/write requests over a valid/ready handshake and drives the memory's `re/raddr` and `we/waddr/wdata` inputs. It captures registered read data one cycle after issue and returns it in order through a buffered response stream. It sits between a core's load/store or fetch path and a memory model instance.

## Interface
Parameters:
- `AWIDTH`, 16: address width; matches the memory port.
- `DWIDTH`, 16: data width; matches the memory port.
- `RSP_DEPTH`, 4: response buffer entries. Must be a power of two and ≥ 2.

Ports:
- `clk` in 1: single clock; all logic on posedge.
- `rst` in 1: reset; synchronous, active-high.
- `req_valid` in 1: request present.
- `req_ready` out 1: request accepted when `req_valid & req_ready`.
- `req_we` in 1: 1 = write, 0 = read.
- `req_addr` in AWIDTH: request address.
- `req_wdata` in DWIDTH: write data, ignored for reads.
- `rsp_valid` out 1: read response present.
- `rsp_ready` in 1: response consumed when `rsp_valid & rsp_ready`.
- `rsp_rdata` out DWIDTH: read data.
- `rsp_addr` out AWIDTH: address of the read that produced `rsp_rdata`.
- `mem_re` out 1: memory read enable.
- `mem_raddr` out AWIDTH: memory read address.
- `mem_rdata` in DWIDTH: memory read data, registered in the memory, valid the cycle after `mem_re`.
- `mem_we` out 1: memory write enable.
- `mem_waddr` out AWIDTH: memory write address.
- `mem_wdata` out DWIDTH: memory write data.

## Operation
- **Issue (combinational from the accepted request).**
  - Read: `mem_re = req_valid & req_ready & ~req_we`.
  - Write: `mem_we = req_valid & req_ready & req_we`.
  - Address and data pass straight through: `mem_raddr = mem_waddr = req_addr`, `mem_wdata = req_wdata`.
  - Both enables are forced to 0 while `rst` is high.
- **Writes are posted.** They produce no response. They are issued in request order with reads, so a read after a write to the same address returns the new data.
- **Read tracking.**
  - A read issued in cycle N sets the 1-bit `inflight` flag and registers the address in `inflight_addr`.
  - In cycle N+1, `{inflight_addr, mem_rdata}` is pushed into the response FIFO at the clock edge, and `inflight` clears unless another read issued in N+1.
  - `mem_rdata` is sampled only when `inflight` = 1. At all other times it is ignored.
- **Credit rule.**
  - `req_ready = ~rst & ((occupancy + inflight) < RSP_DEPTH)`. It applies to reads and writes alike and does not depend on `req_valid`, `req_we` or the same-cycle `rsp_ready`.
  - As a result the FIFO never overflows, and there is no combinational path from `rsp_ready` to `req_ready`.
- **Response FIFO.** In-order, RSP_DEPTH entries. `rsp_valid` means not empty; the head drives `rsp_rdata`/`rsp_addr`.
  - Push and pop in the same cycle leave occupancy unchanged.
  - Pointers wrap modulo RSP_DEPTH.
  - The occupancy counter is `$clog2(RSP_DEPTH)+1` bits wide.
- **Backpressure.**
  - When `rsp_ready` is held low, at most RSP_DEPTH reads are outstanding, after which `req_ready` drops.
  - While the response stream is stalled, writes are also stalled once credit is exhausted.
- **Reset (synchronous).** The following take effect at the first edge with `rst` = 1 and hold while `rst` is high:
  - `inflight` = 0, and the FIFO is flushed (occupancy 0, pointers 0).
  - `rsp_valid` = 0, `rsp_rdata` = 0, `rsp_addr` = 0.
  - `req_ready` = 0, `mem_re` = 0, `mem_we` = 0.
  - A read in flight when `rst` asserts is discarded. Its `mem_rdata` is not pushed.

## Timing
- Read accepted in cycle N → `mem_re` high in N → `mem_rdata` valid in N+1 → `rsp_valid` high in N+2 (FIFO previously empty). Read-to-response latency is 2 cycles.
- Write accepted in cycle N → `mem_we` high in N → memory updated at the end of N.
- Throughput is one request per cycle sustained, provided `rsp_ready` = 1 and RSP_DEPTH ≥ 4. With RSP_DEPTH = 2, a continuous read stream takes one request per cycle for 2 cycles, then `req_ready` drops and the stream issues at a reduced rate.
- `rsp_valid`, `rsp_rdata` and `rsp_addr` are registered outputs. `req_ready` is derived from registered state only.

## Configuration
- `MEM_MASTER_STATS_EN` defined: adds two output ports, each reset to 0 by `rst` and wrapping at 2^32 − 1 → 0:
  - `stat_rd_count` out 32: increments on each accepted read.
  - `stat_wr_count` out 32: increments on each accepted write.
- Not defined: the ports and counters are absent. All other behaviour is identical.

## Structure
- Shared package `mem_pkg`:
  - Typedefs `mem_addr_t` and `mem_data_t`, sized from the AWIDTH/DWIDTH defaults.
  - Packed struct `mem_rsp_t {addr, data}`.
  - Constant `MEM_READ_LATENCY = 1`.
- Sub-module `sync_fifo`: parameterized on width and depth, holding the `mem_rsp_t` response entries. It exposes `push`, `pop`, `full`, `empty` and `count`. The issue and credit logic stays in `mem_master`.

## Test plan
- **Read after reset.** Preload addr 0x0010 = 0xBEEF. Read 0x0010 in cycle N. Required: `mem_re` high only in N, with `mem_raddr` = 0x0010; `rsp_valid` high in N+2 with `rsp_rdata` = 0xBEEF and `rsp_addr` = 0x0010.
- **Write then read.** Write 0x0020 ← 0x1234, then read 0x0020 the next cycle. Required: `mem_we` pulses once; the read response is 0x1234; no response is produced for the write.
- **Backpressure.** Hold `rsp_ready` = 0 and issue 6 back-to-back reads to 0x0..0x5. Required: exactly 4 accepted; `req_ready` = 0 thereafter. Release `rsp_ready`: responses 0x0..0x3 arrive in order, then the remaining 2 reads complete.
- **Streaming.** 64 alternating reads and writes with `rsp_ready` = 1 and RSP_DEPTH = 4. Required: `req_ready` stays 1 throughout; all 32 read responses match a reference model in order.
- **Reset mid-flight.** Assert `rst` in the cycle after a read issues, with 2 responses buffered. Required: `rsp_valid` = 0 and `req_ready` = 0 from the next cycle; no stale response after `rst` deasserts; first post-reset read latency is 2 cycles.
- **Stats (with `MEM_MASTER_STATS_EN`).** 5 reads and 3 writes. Required: `stat_rd_count` = 5 and `stat_wr_count` = 3; both return to 0 after `rst`.
